// File: rtl/regfile_write_port_pkg.sv
// Shared constants and types for the register-file write side.
package regfile_pkg;
    localparam int unsigned NUM_REGS = 32;
    localparam int unsigned ADDR_W   = 5;
    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd31;

    typedef logic [ADDR_W-1:0] reg_addr_t;
endpackage

// File: rtl/regfile_write_port_if.sv
// Write-port bundle: master drives the write request, slave returns the
// bit-sliced register view and the decoded enables.
interface regfile_write_port_if
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64
);
    logic                                wr_en;
    reg_addr_t                           wr_addr;
    logic [WIDTH-1:0]                    wr_data;
    logic [WIDTH-1:0][NUM_REGS-1:0]      slices;
    logic [NUM_REGS-1:0]                 wr_onehot;

    modport master (
        output wr_en, wr_addr, wr_data,
        input  slices, wr_onehot
    );

    modport slave (
        input  wr_en, wr_addr, wr_data,
        output slices, wr_onehot
    );
endinterface

// File: rtl/regfile_write_port_decoder5_32.sv
// 5:32 write-address decoder: a 2:4 stage on addr[4:3] gated by the enable,
// feeding four 3:8 stages on addr[2:0]. The zero register never decodes.
module decoder5_32
    import regfile_pkg::*;
#(
    parameter int DELAY = 50
) (
    input  logic                en_i,
    input  reg_addr_t           addr_i,
    output logic [NUM_REGS-1:0] onehot_o
);
    localparam logic [NUM_REGS-1:0] WR_MASK = ~(NUM_REGS'(1) << ZERO_REG);

    logic [3:0]          grp_en;
    logic [NUM_REGS-1:0] dec;

    if (DELAY < 0) begin : g_delay_chk
        $error("decoder5_32: DELAY must be non-negative");
    end

    // Gating by en_i first keeps an unknown address from leaking into any enable.
    for (genvar g = 0; g < 4; g++) begin : g_hi
        assign grp_en[g] = en_i & (addr_i[4:3] == 2'(g));
        for (genvar j = 0; j < 8; j++) begin : g_lo
            assign dec[g*8+j] = grp_en[g] & (addr_i[2:0] == 3'(j));
        end
    end

    assign onehot_o = dec & WR_MASK;
endmodule

// File: rtl/regfile_write_port.sv
// Register-file write side: 31 enable registers plus a constant-zero r31,
// presented bit-sliced for the per-bit read muxes. Optional same-cycle
// write bypass under `REGFILE_BYPASS_EN.
module regfile_write_port
    import regfile_pkg::*;
#(
    parameter int unsigned WIDTH = 64,
    parameter int          DELAY = 50
) (
    input  logic               clk,
    input  logic               reset,
    regfile_write_port_if.slave bus
);
    logic [NUM_REGS-1:0]            onehot;
    logic [NUM_REGS-1:0][WIDTH-1:0] col;
    logic [WIDTH-1:0][NUM_REGS-1:0] slices;

    decoder5_32 #(.DELAY(DELAY)) u_dec (
        .en_i     (bus.wr_en),
        .addr_i   (bus.wr_addr),
        .onehot_o (onehot)
    );

    assign bus.wr_onehot = onehot;

    for (genvar r = 0; r < NUM_REGS - 1; r++) begin : g_reg
        logic [WIDTH-1:0] data_q, data_d;

        assign data_d = onehot[r] ? bus.wr_data : data_q;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) data_q <= '0;
            else       data_q <= data_d;
        end

`ifdef REGFILE_BYPASS_EN
        // Write-before-read: the column shows the incoming data before the edge.
        assign col[r] = (onehot[r] & ~reset) ? bus.wr_data : data_q;
`else
        assign col[r] = data_q;
`endif
    end

    assign col[ZERO_REG] = '0;

    always_comb begin
        slices = '0;
        for (int i = 0; i < int'(WIDTH); i++)
            for (int r = 0; r < int'(NUM_REGS); r++)
                slices[i][r] = col[r][i];
    end

    assign bus.slices = slices;
endmodule

// File: tb/tb_regfile_write_port.sv
// Directed bench for regfile_write_port: decoder, writes, zero register,
// async reset and a read-mux view of every column.
module tb_regfile_write_port;
    import regfile_pkg::*;

    localparam int unsigned WIDTH = 64;

    logic clk;
    logic reset;
    int   npass;
    int   ntotal;

    regfile_write_port_if #(.WIDTH(WIDTH)) bus ();

    regfile_write_port #(.WIDTH(WIDTH), .DELAY(50)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Per-bit 32:1 read mux model: bit i of the result is slices[i][sel].
    function automatic logic [WIDTH-1:0] mux_read(input int sel);
        logic [WIDTH-1:0] v;
        v = '0;
        for (int i = 0; i < int'(WIDTH); i++) v[i] = bus.slices[i][sel];
        return v;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] obs, input logic [WIDTH-1:0] exp);
        ntotal++;
        assert (obs === exp) npass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic drive(input logic en, input logic [4:0] addr, input logic [WIDTH-1:0] data);
        @(negedge clk);
        bus.wr_en   = en;
        bus.wr_addr = addr;
        bus.wr_data = data;
    endtask

    task automatic edge_wait;
        @(posedge clk);
        #1;
    endtask

    initial begin
        npass  = 0;
        ntotal = 0;

        // Reset holds everything at zero even with a write presented.
        reset       = 1'b1;
        bus.wr_en   = 1'b1;
        bus.wr_addr = 5'd3;
        bus.wr_data = 64'hFFFF_FFFF_FFFF_FFFF;
        edge_wait();
        edge_wait();
        chk("reset_onehot", 64'(bus.wr_onehot), 64'h8);
        for (int r = 0; r < 32; r++) chk($sformatf("reset_col%0d", r), mux_read(r), 64'h0);

        drive(1'b0, 5'd0, 64'h0);
        reset = 1'b0;
        edge_wait();
        chk("idle_onehot", 64'(bus.wr_onehot), 64'h0);

        // Single write to r5.
        drive(1'b1, 5'd5, 64'h0123_4567_89AB_CDEF);
        #1;
        chk("wr5_onehot", 64'(bus.wr_onehot), 64'h20);
`ifdef REGFILE_BYPASS_EN
        chk("wr5_bypass", mux_read(5), 64'h0123_4567_89AB_CDEF);
`else
        chk("wr5_before_edge", mux_read(5), 64'h0);
`endif
        edge_wait();
        bus.wr_en = 1'b0;
        #1;
        chk("wr5_col5", mux_read(5), 64'h0123_4567_89AB_CDEF);
        chk("wr5_col4", mux_read(4), 64'h0);
        chk("wr5_col6", mux_read(6), 64'h0);
        chk("wr5_bit0", 64'(bus.slices[0][5]), 64'h1);
        chk("wr5_bit63", 64'(bus.slices[63][5]), 64'h0);

        // Zero register ignores writes.
        drive(1'b1, 5'd31, 64'hFFFF_FFFF_FFFF_FFFF);
        #1;
        chk("zr_onehot", 64'(bus.wr_onehot), 64'h0);
        chk("zr_col31_pre", mux_read(31), 64'h0);
        edge_wait();
        chk("zr_col31", mux_read(31), 64'h0);
        chk("zr_col30", mux_read(30), 64'h0);

        // Write disabled keeps r7.
        drive(1'b1, 5'd7, 64'h77);
        edge_wait();
        chk("r7_load", mux_read(7), 64'h77);
        drive(1'b0, 5'd7, 64'hDEAD);
        #1;
        chk("dis_onehot", 64'(bus.wr_onehot), 64'h0);
        edge_wait();
        chk("dis_col7", mux_read(7), 64'h77);

        // Unknown address with the strobe low must not disturb anything.
        drive(1'b0, 5'bxxxxx, 64'hBAD0_BAD0);
        #1;
        chk("xaddr_onehot", 64'(bus.wr_onehot), 64'h0);
        edge_wait();
        chk("xaddr_col5", mux_read(5), 64'h0123_4567_89AB_CDEF);
        chk("xaddr_col7", mux_read(7), 64'h77);

        // Back-to-back writes to r9: last wins.
        drive(1'b1, 5'd9, 64'hAAAA_0000_1111_2222);
        edge_wait();
        chk("b2b_first", mux_read(9), 64'hAAAA_0000_1111_2222);
        drive(1'b1, 5'd9, 64'h5555_FFFF_EEEE_DDDD);
        edge_wait();
        chk("b2b_last", mux_read(9), 64'h5555_FFFF_EEEE_DDDD);

        // Top-group decode.
        drive(1'b1, 5'd30, 64'h0);
        #1;
        chk("dec30_onehot", 64'(bus.wr_onehot), 64'h4000_0000);
        drive(1'b1, 5'd16, 64'h0);
        #1;
        chk("dec16_onehot", 64'(bus.wr_onehot), 64'h0001_0000);

        // Sweep r+1 into every register on consecutive cycles.
        for (int r = 0; r < 31; r++) begin
            drive(1'b1, 5'(r), 64'(r + 1));
        end
        drive(1'b0, 5'd0, 64'h0);
        edge_wait();
        for (int s = 0; s < 32; s++)
            chk($sformatf("sweep_sel%0d", s), mux_read(s), (s < 31) ? 64'(s + 1) : 64'h0);

        // Async reset between edges clears immediately.
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        for (int r = 0; r < 32; r++) chk($sformatf("areset_col%0d", r), mux_read(r), 64'h0);
        #1;
        reset = 1'b0;

        drive(1'b1, 5'd2, 64'h55);
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("post_bypass_col2", mux_read(2), 64'h55);
`else
        chk("post_pre_col2", mux_read(2), 64'h0);
`endif
        edge_wait();
        bus.wr_en = 1'b0;
        #1;
        chk("post_col2", mux_read(2), 64'h55);
        chk("post_col0", mux_read(0), 64'h0);
        chk("post_col3", mux_read(3), 64'h0);
        chk("post_col30", mux_read(30), 64'h0);

        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end
endmodule
